// File: rtl/game_timing_ctrl_pkg.sv
// Shared types and constants for the game timing controller.
package game_timing_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      OVER   = 2'd2,
      PAUSED = 2'd3
   } state_e;

   typedef logic [3:0] bcd_digit_t;

   localparam logic [15:0] BCD_MAX = 16'h9999;

endpackage

// File: rtl/game_timing_ctrl_chan_divider.sv
// One tick channel: counts base strobes and emits a registered one-cycle tick
// on the strobe where the count matches div.
module chan_divider #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             strobe,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;

   // Lowering div below cnt lets cnt run on and wrap at 2^DIV_W.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (strobe) begin
            if (cnt == div) begin
               cnt  <= '0;
               tick <= 1'b1;
            end else begin
               cnt <= cnt + DIV_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/game_timing_ctrl.sv
// Game timing controller: prescaler, game-state FSM, tick channels, BCD score.
// Define GAME_PAUSE_EN to add the pause input and the PAUSED state.
module game_timing_ctrl
   import game_timing_pkg::*;
#(
   parameter int PRESCALE = 16000,
   parameter int NCH      = 3,
   parameter int DIV_W    = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 collide,
`ifdef GAME_PAUSE_EN
   input  logic                 pause,
`endif
   input  logic [NCH*DIV_W-1:0] div,
   output logic [NCH-1:0]       tick,
   output logic [1:0]           state,
   output logic [15:0]          score
);

   localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE);

   state_e        st;
   logic [PW-1:0] pcnt;
   logic          strobe;
   logic          clr;
   logic          pause_req;

   function automatic logic [15:0] bcd_inc_sat(input logic [15:0] s);
      logic [15:0] r;
      bcd_digit_t  d;
      logic        carry;
      r     = s;
      carry = (s != BCD_MAX);
      for (int i = 0; i < 4; i++) begin
         d = s[i*4 +: 4];
         if (carry) begin
            if (d == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = d + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

`ifdef GAME_PAUSE_EN
   assign pause_req = pause;
`else
   assign pause_req = 1'b0;
`endif

   // A strobe only counts if the FSM stays in RUN, so no tick lands outside RUN.
   assign strobe = (st == RUN) && (pcnt == PS_LAST) && !collide && !pause_req;
   assign clr    = (st == IDLE) && start;
   assign state  = st;

   always_ff @(posedge clk) begin
      if (reset) begin
         st    <= IDLE;
         pcnt  <= '0;
         score <= '0;
      end else begin
         case (st)
            IDLE: begin
               if (start) begin
                  st    <= RUN;
                  pcnt  <= '0;
                  score <= '0;
               end
            end
            RUN: begin
               pcnt <= (pcnt == PS_LAST) ? '0 : pcnt + PW'(1);
               if (tick[0]) score <= bcd_inc_sat(score);
               if (collide) st <= OVER;
`ifdef GAME_PAUSE_EN
               else if (pause) st <= PAUSED;
`endif
            end
            OVER: begin
               if (start) st <= IDLE;
            end
`ifdef GAME_PAUSE_EN
            PAUSED: begin
               if (pause) st <= RUN;
            end
`endif
            default: st <= IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      chan_divider #(.DIV_W(DIV_W)) u_chan (
         .clk    (clk),
         .reset  (reset),
         .clr    (clr),
         .strobe (strobe),
         .div    (div[i*DIV_W +: DIV_W]),
         .tick   (tick[i])
      );
   end

endmodule

// File: tb/tb_game_timing_ctrl.sv
// Scoreboard bench for game_timing_ctrl with PRESCALE=3, div={2,1,0}.
module tb_game_timing_ctrl;

   localparam int F_ST = 0;
   localparam int F_TK = 1;
   localparam int F_SC = 2;

   typedef struct {
      int          at;
      int          fld;
      logic [15:0] val;
      string       tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        collide = 1'b0;
`ifdef GAME_PAUSE_EN
   logic        pause = 1'b0;
`endif
   logic [23:0] div = {8'd2, 8'd1, 8'd0};
   logic [2:0]  tick;
   logic [1:0]  state;
   logic [15:0] score;

   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t sbq[$];
   int   dv[3] = '{0, 1, 2};

   game_timing_ctrl #(.PRESCALE(3), .NCH(3), .DIV_W(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .collide (collide),
`ifdef GAME_PAUSE_EN
      .pause   (pause),
`endif
      .div     (div),
      .tick    (tick),
      .state   (state),
      .score   (score)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   task automatic expect_at(input int at, input int fld, input logic [15:0] v, input string tag);
      exp_t e;
      int   k;
      e.at = at; e.fld = fld; e.val = v; e.tag = tag;
      k = 0;
      while (k < sbq.size() && sbq[k].at <= at) k++;
      sbq.insert(k, e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go_until(input int t);
      while (cyc < t) step();
   endtask

   // Ticks expected c cycles into RUN when the run is uninterrupted.
   function automatic logic [15:0] tick_at(input int c);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < 3; i++)
         if (c > 0 && (c % ((dv[i] + 1) * 4)) == 0) r[i] = 1'b1;
      return r;
   endfunction

   always @(negedge clk) begin : mon
      exp_t        e;
      logic [15:0] obs;
      while (sbq.size() > 0 && sbq[0].at <= cyc) begin
         e = sbq.pop_front();
         case (e.fld)
            F_ST:    obs = {14'd0, state};
            F_TK:    obs = {13'd0, tick};
            default: obs = score;
         endcase
         check_val(e.tag, obs, e.val);
      end
   end

   initial begin : stim
      int b, b2, b3;
      step();
      step();
      expect_at(cyc + 1, F_ST, 16'd0, "rst_state");
      expect_at(cyc + 1, F_TK, 16'd0, "rst_tick");
      expect_at(cyc + 1, F_SC, 16'd0, "rst_score");
      step();
      reset = 1'b0;
      step();

      collide = 1'b1;
      expect_at(cyc + 1, F_ST, 16'd0, "idle_collide");
      step();
      collide = 1'b0;

      // Run 1: tick pattern, BCD carry, collide on a strobe
      start = 1'b1;
      b = cyc + 1;
      expect_at(b, F_ST, 16'd1, "run1_state");
      for (int c = 0; c <= 24; c++) expect_at(b + c, F_TK, tick_at(c), $sformatf("tick_c%0d", c));
      expect_at(b + 4,   F_SC, 16'h0000, "score_c4");
      expect_at(b + 5,   F_SC, 16'h0001, "score_c5");
      expect_at(b + 37,  F_SC, 16'h0009, "score_0009");
      expect_at(b + 41,  F_SC, 16'h0010, "score_0010");
      expect_at(b + 160, F_SC, 16'h0039, "score_0039");
      expect_at(b + 161, F_SC, 16'h0040, "score_0040");
      step();
      start = 1'b0;
      go_until(b + 167);
      collide = 1'b1;
      expect_at(b + 168, F_TK, 16'd0, "collide_strobe_tick");
      expect_at(b + 168, F_ST, 16'd2, "collide_state");
      expect_at(b + 168, F_SC, 16'h0041, "collide_score");
      expect_at(b + 175, F_ST, 16'd2, "over_hold_state");
      expect_at(b + 175, F_SC, 16'h0041, "over_hold_score");
      step();
      collide = 1'b0;
      go_until(b + 176);
      start = 1'b1;
      expect_at(b + 177, F_ST, 16'd0, "over_to_idle");
      expect_at(b + 177, F_SC, 16'h0041, "idle_hold_score");
      step();
      start = 1'b0;
      step();

      // Run 2: saturation, then start+collide together
      start = 1'b1;
      b2 = cyc + 1;
      expect_at(b2, F_ST, 16'd1, "run2_state");
      expect_at(b2, F_SC, 16'h0000, "run2_score_clr");
      expect_at(b2 + 397,   F_SC, 16'h0099, "score_0099");
      expect_at(b2 + 401,   F_SC, 16'h0100, "score_0100");
      expect_at(b2 + 39996, F_SC, 16'h9998, "score_9998");
      expect_at(b2 + 39997, F_SC, 16'h9999, "score_9999");
      expect_at(b2 + 40050, F_SC, 16'h9999, "score_sat");
      step();
      start = 1'b0;
      go_until(b2 + 40052);
      start = 1'b1;
      collide = 1'b1;
      expect_at(cyc + 1, F_ST, 16'd2, "start_collide");
      step();
      collide = 1'b0;
      expect_at(cyc + 1, F_ST, 16'd0, "over_to_idle2");
      step();
      start = 1'b0;
      step();

      // Run 3: reset mid-run with ticks pending
      start = 1'b1;
      b3 = cyc + 1;
      expect_at(b3 + 8,  F_TK, 16'h0003, "run3_tick_c8");
      expect_at(b3 + 11, F_SC, 16'h0002, "run3_score");
      expect_at(b3 + 12, F_ST, 16'd0, "midrst_state");
      expect_at(b3 + 12, F_TK, 16'd0, "midrst_tick");
      expect_at(b3 + 12, F_SC, 16'd0, "midrst_score");
      step();
      start = 1'b0;
      go_until(b3 + 11);
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();

`ifdef GAME_PAUSE_EN
      begin : pause_test
         int b4;
         start = 1'b1;
         b4 = cyc + 1;
         expect_at(b4, F_ST, 16'd1, "run4_state");
         step();
         start = 1'b0;
         go_until(b4 + 6);
         pause = 1'b1;
         expect_at(b4 + 7, F_ST, 16'd3, "paused_state");
         for (int c = 7; c <= 16; c++) expect_at(b4 + c, F_TK, 16'd0, $sformatf("paused_tick_c%0d", c));
         expect_at(b4 + 12, F_SC, 16'h0001, "paused_score");
         step();
         pause = 1'b0;
         go_until(b4 + 10);
         collide = 1'b1;
         expect_at(b4 + 11, F_ST, 16'd3, "paused_collide");
         step();
         collide = 1'b0;
         go_until(b4 + 16);
         pause = 1'b1;
         expect_at(b4 + 17, F_ST, 16'd1, "resume_state");
         expect_at(b4 + 17, F_TK, 16'd0, "resume_tick_c17");
         expect_at(b4 + 18, F_TK, 16'h0003, "resume_tick_c18");
         step();
         pause = 1'b0;
         go_until(b4 + 20);
      end
`endif

      go_until(cyc + 3);
      while (sbq.size() > 0) begin
         check_val({"leftover_", sbq[0].tag}, 16'd1, 16'd0);
         void'(sbq.pop_front());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/game_timing_ctrl.md
# game_timing_ctrl

Central timing controller for the game. It owns one prescaler that produces a base strobe every PRESCALE+1 clocks, and divides that strobe into NCH independent one-cycle tick channels (gravity, pipe scroll, score rate, …). A game-state FSM gates the prescaler, the channels and a BCD score counter. It sits between the input/collision logic and every block that currently runs its own free-running cycle counter; those blocks consume its ticks instead.

## Interface
- PRESCALE, 16000: base strobe when prescaler count == PRESCALE; period PRESCALE+1 clocks.
- NCH, 3: number of tick channels, ≥1; channel 0 drives the score.
- DIV_W, 8: width of each channel divide value.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse, debounced upstream.
- collide  in  1  level, from collision detect.
- pause  in  1  one-cycle toggle pulse; present only with GAME_PAUSE_EN.
- div  in  NCH*DIV_W  channel i divide value at bits [i*DIV_W +: DIV_W]; quasi-static.
- tick  out  NCH  registered one-cycle channel strobes.
- state  out  2  IDLE=0, RUN=1, OVER=2, PAUSED=3.
- score  out  16  four BCD digits, most significant digit in [15:12].

## Operation
- Reset: state=IDLE, prescaler=0, all channel counters=0, tick=0, score=0.
- FSM:
  - IDLE → RUN on start. On this transition the prescaler, channel counters and score all clear.
  - RUN → OVER on collide. collide wins over a simultaneous start or pause.
  - OVER → IDLE on start. score holds through OVER and IDLE until the next IDLE → RUN.
  - collide is ignored in IDLE and OVER.
- Prescaler: width $clog2(PRESCALE+1). Counts only in RUN. Wraps to 0 after PRESCALE; the base strobe is count==PRESCALE.
- Channel i:
  - Counter of DIV_W bits advances once per base strobe.
  - When a base strobe occurs with counter==div[i], the counter wraps to 0 and tick[i] is set for the next cycle.
  - div[i]=0 gives one tick per base strobe.
  - Tick period is (div[i]+1)*(PRESCALE+1) clocks.
  - If div[i] is lowered below the current counter value, the counter wraps naturally at 2^DIV_W. This is a legal but slow boundary case.
- A tick is generated only from a base strobe in a RUN cycle with collide low. tick is 0 in every non-RUN cycle.
- Score: on each clock edge where tick[0]=1 and state=RUN, score increments by 1 in BCD with digit carry. It saturates at 9999.
- Outside RUN, all counters hold their value, except on the IDLE → RUN clear.
- reset mid-game returns to the reset values on the next edge, regardless of other inputs.

## Timing
- Let cycle 0 be the first cycle with state=RUN.
- The base strobe occurs in cycle PRESCALE. With div[i]=d, the first tick[i] is high in cycle (d+1)(PRESCALE+1).
- score changes in the cycle after tick[0] is high.
- start/collide/pause sampled in cycle n update state in cycle n+1.
- A strobe in the collide cycle produces no tick.

## Configuration
- GAME_PAUSE_EN defined:
  - Adds the pause port and the PAUSED state.
  - RUN → PAUSED on pause; PAUSED → RUN on pause.
  - In PAUSED, counters hold (not cleared), tick=0, and start and collide are ignored.
  - On resume, counting continues from the held values.
- GAME_PAUSE_EN undefined: no pause port; state never equals 3.

## Structure
- Package game_timing_pkg holds:
  - state_e enum with the encodings above.
  - The BCD digit type.
  - The BCD_MAX constant of 9999.
- Sub-module chan_divider: one instance per channel via generate. Inputs: clk, reset, clr, strobe, div. Output: the registered tick.
- The prescaler, FSM and score counter live in the top module.

## Test plan
Directed tests use PRESCALE=3, NCH=3, div={2,1,0} for channels 2,1,0.
- Reset, then start: state=1 from cycle 0. tick[0] high at cycles 4, 8, 12. tick[1] high at cycles 8, 16. tick[2] high at cycles 12, 24. score=0001 at cycle 5.
- Let RUN continue for 40 base strobes: score=0040 in BCD (digit carry 0009 → 0010 checked). Preload-style long run: saturates at 9999 and does not wrap.
- collide asserted in the same cycle as a base strobe: no tick; state=2 next cycle; score frozen. A following start gives IDLE; a second start gives RUN with score=0000.
- start and collide asserted together in RUN: state=2. collide in IDLE: state stays 0.
- reset asserted mid-RUN with tick pending: all outputs at reset values on the next cycle.
- GAME_PAUSE_EN: pause at cycle 6 holds the prescaler with no ticks for 10 cycles. A second pause resumes, and the next tick[0] occurs 2 cycles after resume. collide while PAUSED is ignored.
